// File: rtl/ex_md_stage_if.sv
// Execute/multiply-divide stage bus: upstream capture inputs, downstream handoff and decode forward path.
// master drives the stage inputs, slave is the stage itself.
interface ex_md_stage_if #(
   parameter int DATA_LEN = 32
);
   logic                ds_valid_i;
   logic                es_allowin_o;
   logic                md_en_i;
   logic [2:0]          md_op_i;
   logic [DATA_LEN-1:0] src1_i;
   logic [DATA_LEN-1:0] src2_i;
   logic [DATA_LEN-1:0] byp_i;
   logic                wd_i;
   logic [4:0]          wreg_i;
   logic                flush_i;
   logic                ms_allowin_i;
   logic                es_to_ms_valid_o;
   logic [DATA_LEN-1:0] result_o;
   logic                wd_o;
   logic [4:0]          wreg_o;
   logic                fwd_valid_o;
   logic                fwd_stall_o;
   logic [DATA_LEN-1:0] fwd_data_o;

   modport master (
      output ds_valid_i, md_en_i, md_op_i, src1_i, src2_i, byp_i, wd_i, wreg_i,
             flush_i, ms_allowin_i,
      input  es_allowin_o, es_to_ms_valid_o, result_o, wd_o, wreg_o,
             fwd_valid_o, fwd_stall_o, fwd_data_o
   );

   modport slave (
      input  ds_valid_i, md_en_i, md_op_i, src1_i, src2_i, byp_i, wd_i, wreg_i,
             flush_i, ms_allowin_i,
      output es_allowin_o, es_to_ms_valid_o, result_o, wd_o, wreg_o,
             fwd_valid_o, fwd_stall_o, fwd_data_o
   );
endinterface

// File: rtl/ex_md_stage.sv
// Execute stage with iterative RV M-extension unit; non-MD results ready 1 cycle after capture, MUL/DIV after DATA_LEN cycles.
// Backpressure: es_allowin_o drops while iterating or while a result waits on ms_allowin_i; outputs hold until handoff.
module ex_md_stage #(
   parameter int DATA_LEN = 32,
   parameter int CNT_W    = 6
) (
   input logic         clock,
   input logic         reset,
   ex_md_stage_if.slave md
);
   localparam int N = DATA_LEN;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic             es_valid;
   logic [CNT_W-1:0] cnt;
   logic             md_r;
   logic [2:0]       op_r;
   logic             wd_r;
   logic [4:0]       wreg_r;
   logic [N-1:0]     res_r;
   logic [N-1:0]     hi;
   logic [N-1:0]     lo;
   logic [N-1:0]     b;
   logic             neg_q;
   logic             neg_r;

   logic ready_go, es_allowin, capture, handoff;

   assign ready_go   = !md_r || (state != BUSY);
   assign es_allowin = !es_valid || (ready_go && md.ms_allowin_i);
   assign capture    = md.ds_valid_i && es_allowin && !md.flush_i;
   assign handoff    = es_valid && ready_go && md.ms_allowin_i;

   // Operand decode: iterate on magnitudes, remember result signs.
   logic         is_div, sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
   logic [N-1:0] mag1, mag2, spec_res;

   assign is_div   = md.md_op_i[2];
   assign sgn1     = is_div ? !md.md_op_i[0] : (md.md_op_i == 3'd1 || md.md_op_i == 3'd2);
   assign sgn2     = is_div ? !md.md_op_i[0] : (md.md_op_i == 3'd1);
   assign neg1     = sgn1 && md.src1_i[N-1];
   assign neg2     = sgn2 && md.src2_i[N-1];
   assign mag1     = neg1 ? -md.src1_i : md.src1_i;
   assign mag2     = neg2 ? -md.src2_i : md.src2_i;
   assign div_zero = is_div && (md.src2_i == '0);
   assign div_ovf  = is_div && !md.md_op_i[0] && (md.src1_i == {1'b1, {(N-1){1'b0}}})
                     && (md.src2_i == '1);
   assign spec_res = div_zero ? (md.md_op_i[1] ? md.src1_i : '1)
                              : (md.md_op_i[1] ? '0 : md.src1_i);

   // One iteration: shift-add for multiply, restoring step for divide.
   logic [N:0]     mul_sum, div_sh, div_diff;
   logic [N-1:0]   step_hi, step_lo, q_s, r_s, fin;
   logic [2*N-1:0] prod, prod_s;

   always_comb begin
      mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
      div_sh   = {hi, lo[N-1]};
      div_diff = div_sh - {1'b0, b};
      step_hi  = mul_sum[N:1];
      step_lo  = {mul_sum[0], lo[N-1:1]};
      if (op_r[2]) begin
         if (!div_diff[N]) begin
            step_hi = div_diff[N-1:0];
            step_lo = {lo[N-2:0], 1'b1};
         end else begin
            step_hi = div_sh[N-1:0];
            step_lo = {lo[N-2:0], 1'b0};
         end
      end
      prod   = {step_hi, step_lo};
      prod_s = neg_q ? -prod : prod;
      q_s    = neg_q ? -step_lo : step_lo;
      r_s    = neg_r ? -step_hi : step_hi;
      case (op_r)
         3'd0:                fin = prod_s[N-1:0];
         3'd1, 3'd2, 3'd3:    fin = prod_s[2*N-1:N];
         3'd4, 3'd5:          fin = q_s;
         default:             fin = r_s;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         es_valid <= 1'b0;
         cnt      <= '0;
         md_r     <= 1'b0;
         op_r     <= '0;
         wd_r     <= 1'b0;
         wreg_r   <= '0;
         res_r    <= '0;
         hi       <= '0;
         lo       <= '0;
         b        <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
      end else if (md.flush_i) begin
         es_valid <= 1'b0;
         state    <= IDLE;
         cnt      <= '0;
      end else begin
         if (es_allowin)
            es_valid <= md.ds_valid_i;
         if (capture) begin
            md_r   <= md.md_en_i;
            op_r   <= md.md_op_i;
            wd_r   <= md.wd_i;
            wreg_r <= md.wreg_i;
            hi     <= '0;
            lo     <= is_div ? mag1 : mag2;
            b      <= is_div ? mag2 : mag1;
            neg_q  <= neg1 ^ neg2;
            neg_r  <= neg1;
            cnt    <= '0;
            if (!md.md_en_i) begin
               res_r <= md.byp_i;
               state <= IDLE;
            end else if (div_zero || div_ovf) begin
               res_r <= spec_res;
               state <= DONE;
            end else begin
               state <= BUSY;
               cnt   <= CNT_W'(N);
            end
         end else begin
            case (state)
               BUSY: begin
                  hi  <= step_hi;
                  lo  <= step_lo;
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     res_r <= fin;
                     state <= DONE;
                  end
               end
               DONE: if (handoff) state <= IDLE;
               default: ;
            endcase
         end
      end
   end

   assign md.es_allowin_o     = es_allowin;
   assign md.es_to_ms_valid_o = es_valid && ready_go;
   assign md.result_o         = res_r;
   assign md.wd_o             = wd_r;
   assign md.wreg_o           = wreg_r;
   assign md.fwd_valid_o      = es_valid && wd_r && (wreg_r != 5'd0) && ready_go;
   assign md.fwd_stall_o      = es_valid && wd_r && (wreg_r != 5'd0) && !ready_go;
   assign md.fwd_data_o       = res_r;
endmodule

// File: doc/ex_md_stage.md
EX_MD_STAGE -- requirements
Module: ysyx_23060025_ex_md_stage

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width (2**CNT_W > DATA_LEN).
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 ds_valid_i  input  1  upstream instruction valid.
REQ-006 es_allowin_o  output  1  stage can accept this cycle.
REQ-007 md_en_i  input  1  instruction is RV M-extension op.
REQ-008 md_op_i  input  3  funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU.
REQ-009 src1_i, src2_i  input  DATA_LEN  operands.
REQ-010 byp_i  input  DATA_LEN  precomputed result for non-MD ops.
REQ-011 wd_i  input  1  writes register; wreg_i  input  5  destination.
REQ-012 flush_i  input  1  kill in-flight instruction.
REQ-013 ms_allowin_i  input  1  downstream can accept.
REQ-014 es_to_ms_valid_o  output  1  result valid to downstream.
REQ-015 result_o  output  DATA_LEN; wd_o output 1; wreg_o output 5  latched/computed result and destination.
REQ-016 fwd_valid_o  output  1; fwd_stall_o  output  1; fwd_data_o  output  DATA_LEN  forward path to decode.

Function
REQ-017 SHALL latch all inputs when ds_valid_i & es_allowin_o & !flush_i (capture edge); es_valid set to ds_valid_i whenever es_allowin_o & !flush_i.
REQ-018 es_allowin_o = !es_valid | (ready_go & ms_allowin_i); es_to_ms_valid_o = es_valid & ready_go.
REQ-019 FSM states IDLE, BUSY, DONE; ready_go = (state != BUSY) for valid MD ops, 1 for non-MD ops.
REQ-020 Non-MD capture: result_o = byp_i, state stays IDLE, es_to_ms_valid_o high the cycle after capture edge.
REQ-021 MD capture, non-special: state IDLE->BUSY, counter loaded DATA_LEN; each BUSY edge performs one iteration and decrements; counter reaching 0 -> DONE; es_to_ms_valid_o first high after the DATA_LEN-th edge following capture.
REQ-022 Multiply: radix-2 shift-add on 2*DATA_LEN-bit product, operand signedness per op (MULHSU: src1 signed, src2 unsigned); MUL returns low half, MULH/MULHSU/MULHU high half.
REQ-023 Divide: restoring radix-2 on magnitudes; quotient negated when signs differ (DIV), remainder takes dividend sign (REM).
REQ-024 Divide by zero: no iteration, IDLE->DONE at capture; quotient all-ones, remainder = src1; valid next cycle.
REQ-025 Signed overflow (src1 = most-negative, src2 = -1, DIV/REM): no iteration; quotient = src1, remainder 0; valid next cycle.
REQ-026 DONE->IDLE when result handed off (es_to_ms_valid_o & ms_allowin_i) and no new capture; DONE/IDLE->BUSY directly if a new iterative MD op is captured on that edge.
REQ-027 result_o, wd_o, wreg_o SHALL be stable while es_to_ms_valid_o & !ms_allowin_i.
REQ-028 fwd_valid_o = es_valid & wd & wreg!=0 & ready_go; fwd_stall_o = es_valid & wd & wreg!=0 & !ready_go; fwd_data_o = result_o.
REQ-029 flush_i: next edge es_valid=0, state=IDLE, counter=0, no capture that cycle; any BUSY op abandoned.
REQ-030 Operand registers SHALL not change during BUSY (es_allowin_o is 0 then).

Reset
REQ-031 On reset: es_valid=0, state IDLE, counter 0, all datapath registers 0; all outputs 0 except es_allowin_o=1.
REQ-032 Reset SHALL override flush and capture, including mid-BUSY.

Verification
REQ-033 MUL 7 x -3 (DATA_LEN 32), ms_allowin_i=1 -> es_to_ms_valid_o high exactly 32 edges after capture, result 0xFFFFFFEB; fwd_stall_o high during BUSY.
REQ-034 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-035 DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF one cycle after capture; REM 0x80000000/-1 -> 0.
REQ-036 Non-MD op with ms_allowin_i=0 for 3 cycles -> result_o=byp_i held, es_allowin_o=0 until handoff, back-to-back ops then accepted every cycle.
REQ-037 flush_i at BUSY cycle 10 -> es_to_ms_valid_o never asserts for that op, next op accepted following cycle with correct result.
REQ-038 reset asserted mid-BUSY -> all outputs at reset values next cycle, es_allowin_o=1.
